// File: rtl/dm_pkg.sv
// Shared encodings and helpers for the data-memory access unit.
package dm_pkg;

  localparam logic [31:0]  DM_BASE_DEFAULT  = 32'h1001_0000;
  localparam int unsigned  DM_BYTES_DEFAULT = 640;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_ILL = 2'b11;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_ADEL = 2'b01;
  localparam logic [1:0] EXC_ADES = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dm_state_e;

  // Request attributes kept across ACCESS for the load extension.
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       uns;
  } dm_req_t;

  // Number of bytes touched by an access; 0 for the illegal size.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  size_bytes = 3'd1;
      SIZE_H:  size_bytes = 3'd2;
      SIZE_W:  size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

  // Store lane enables, right-aligned at DM_addr.
  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  lane_mask = 4'b0001;
      SIZE_H:  lane_mask = 4'b0011;
      SIZE_W:  lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // Natural-alignment check on the low CPU address bits.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SIZE_H:  misaligned = a[0];
      SIZE_W:  misaligned = |a;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Sign/zero extension of raw data-memory read data.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] raw_i,
  output logic [31:0] ext_o
);

  // Select the low byte/half and extend; words pass through.
  always_comb begin
    ext_o = raw_i;
    case (size_i)
      SIZE_B:  ext_o = uns_i ? {24'h0, raw_i[7:0]}  : {{24{raw_i[7]}}, raw_i[7:0]};
      SIZE_H:  ext_o = uns_i ? {16'h0, raw_i[15:0]} : {{16{raw_i[15]}}, raw_i[15:0]};
      default: ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// MEM-stage initiator: one load/store at a time, checked, rebased and answered.
module dm_access_unit
  import dm_pkg::*;
#(
  parameter logic [31:0] DM_BASE  = DM_BASE_DEFAULT,
  parameter int unsigned DM_BYTES = DM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_exc,
  output logic        ena,
  output logic        DM_W,
  output logic        DM_R,
  output logic [3:0]  byteEna,
  output logic [31:0] DM_addr,
  output logic [31:0] DM_wdata,
  input  logic [31:0] DM_rdata
);

  dm_state_e   state_q, state_d;
  dm_req_t     lat_q, lat_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [1:0]  resp_exc_q, resp_exc_d;
  logic        ena_q, ena_d;
  logic        dm_w_q, dm_w_d;
  logic        dm_r_q, dm_r_d;
  logic [3:0]  byte_ena_q, byte_ena_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;

  logic [31:0] off_c;
  logic [32:0] end_c;
  logic        fault_c;
  logic [31:0] ext_c;

  // Rebase and range/alignment check; the sum is 33 bits so wrapped offsets cannot pass.
  assign off_c   = req_addr - DM_BASE;
  assign end_c   = {1'b0, off_c} + 33'(size_bytes(req_size));
  assign fault_c = (req_size == SIZE_ILL) || misaligned(req_size, req_addr[1:0]) ||
                   (end_c > 33'(DM_BYTES));

  dm_load_ext u_load_ext (
    .size_i (lat_q.size),
    .uns_i  (lat_q.uns),
    .raw_i  (DM_rdata),
    .ext_o  (ext_c)
  );

  // Next state and next registered outputs; memory-side outputs default to 0.
  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_exc_d   = resp_exc_q;
    ena_d        = 1'b0;
    dm_w_d       = 1'b0;
    dm_r_d       = 1'b0;
    byte_ena_d   = 4'b0000;
    dm_addr_d    = '0;
    dm_wdata_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          lat_d       = '{we: req_we, size: req_size, uns: req_unsigned};
          req_ready_d = 1'b0;
          if (fault_c) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_exc_d   = req_we ? EXC_ADES : EXC_ADEL;
          end else begin
            state_d    = ST_ACCESS;
            ena_d      = 1'b1;
            dm_w_d     = req_we;
            dm_r_d     = ~req_we;
            byte_ena_d = req_we ? lane_mask(req_size) : 4'b0000;
            dm_addr_d  = off_c;
            dm_wdata_d = req_we ? req_wdata : '0;
          end
        end
      end
      ST_ACCESS: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_exc_d   = EXC_NONE;
        resp_rdata_d = lat_q.we ? '0 : ext_c;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_exc_d   = EXC_NONE;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      lat_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_exc_q   <= EXC_NONE;
      ena_q        <= 1'b0;
      dm_w_q       <= 1'b0;
      dm_r_q       <= 1'b0;
      byte_ena_q   <= 4'b0000;
      dm_addr_q    <= '0;
      dm_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_exc_q   <= resp_exc_d;
      ena_q        <= ena_d;
      dm_w_q       <= dm_w_d;
      dm_r_q       <= dm_r_d;
      byte_ena_q   <= byte_ena_d;
      dm_addr_q    <= dm_addr_d;
      dm_wdata_q   <= dm_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_exc   = resp_exc_q;
  assign ena        = ena_q;
  assign DM_W       = dm_w_q;
  assign DM_R       = dm_r_q;
  assign byteEna    = byte_ena_q;
  assign DM_addr    = dm_addr_q;
  assign DM_wdata   = dm_wdata_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Randomized bench for dm_access_unit with a byte-array reference model.
module tb_dm_access_unit;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          BYTES = 640;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_exc;
  logic        ena, DM_W, DM_R;
  logic [3:0]  byteEna;
  logic [31:0] DM_addr, DM_wdata;
  logic [31:0] DM_rdata;

  logic [7:0]  mem [BYTES];
  logic [7:0]  ref_mem [BYTES];
  int          ena_cycles = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  dm_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_exc(resp_exc), .ena(ena), .DM_W(DM_W),
    .DM_R(DM_R), .byteEna(byteEna), .DM_addr(DM_addr), .DM_wdata(DM_wdata),
    .DM_rdata(DM_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: falling-edge write, combinational read.
  initial begin
    for (int i = 0; i < BYTES; i++) mem[i] = 8'(i * 37 + 5);
    forever begin
      @(negedge clk);
      if (ena && DM_W)
        for (int k = 0; k < 4; k++)
          if (byteEna[k] && (DM_addr + 32'(k) < 32'(BYTES)))
            mem[DM_addr + 32'(k)] = DM_wdata[8*k +: 8];
    end
  end

  always_comb begin
    DM_rdata = '0;
    for (int k = 0; k < 4; k++)
      if (DM_addr + 32'(k) < 32'(BYTES)) DM_rdata[8*k +: 8] = mem[DM_addr + 32'(k)];
  end

  always @(posedge clk) if (ena) ena_cycles <= ena_cycles + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference: decide fault from byte arithmetic, then read/write the byte array.
  task automatic model(input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output bit fault, output logic [1:0] exc,
                       output logic [31:0] rd, output logic [31:0] off);
    int     n;
    longint o, v;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    o = longint'(addr) - longint'(BASE);
    if (o < 0) o += (longint'(1) << 32);
    off = 32'(o);
    fault = (n == 0) || ((longint'(addr) % longint'(n)) != 0) || (o + n > BYTES);
    rd = '0;
    exc = fault ? (we ? 2'b10 : 2'b01) : 2'b00;
    if (!fault) begin
      if (we) begin
        for (int k = 0; k < n; k++) ref_mem[int'(o) + k] = 8'(wd >> (8 * k));
      end else begin
        v = 0;
        for (int k = 0; k < n; k++) v += longint'(ref_mem[int'(o) + k]) << (8 * k);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        rd = 32'(v);
      end
    end
  endtask

  task automatic scramble();
    req_valid    = 1'($urandom);
    req_we       = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  // One full transaction, called #1 after a rising edge with the unit idle.
  task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd, input int hold);
    bit fault; logic [1:0] exc; logic [31:0] rd, off; int cnt0; logic [3:0] be;
    model(we, size, uns, addr, wd, fault, exc, rd, off);
    be = !we ? 4'b0000 : (size == 2'd0) ? 4'b0001 : (size == 2'd1) ? 4'b0011 : 4'b1111;
    cnt0 = ena_cycles;
    for (int i = 0; i < 20 && !req_ready; i++) begin @(posedge clk); #1; end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    scramble();
    if (!fault) begin
      check("access_ena", 32'(ena), 32'd1);
      check("access_w_r", {30'd0, DM_W, DM_R}, {30'd0, we, ~we});
      check("access_byteEna", 32'(byteEna), 32'(be));
      check("access_addr", DM_addr, off);
      if (we) check("access_wdata", DM_wdata, wd);
      check("access_no_resp", 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
      scramble();
      check("resp_ena_low", 32'(ena), 32'd0);
    end
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_busy", 32'(req_ready), 32'd0);
    check("resp_rdata", resp_rdata, rd);
    check("resp_exc", 32'(resp_exc), 32'(exc));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      scramble();
      check("hold_valid", {req_ready, resp_valid}, 32'd1);
      check("hold_rdata", resp_rdata, rd);
      check("hold_exc", 32'(resp_exc), 32'(exc));
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    check("done_idle", {req_ready, resp_valid}, 32'd2);
    check("ena_count", 32'(ena_cycles - cnt0), fault ? 32'd0 : 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit f; logic [1:0] e; logic [31:0] r, o; int cnt0; int nmis;
    for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'(i * 37 + 5);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_outs", {resp_valid, ena, DM_W, DM_R, byteEna, resp_exc}, 32'd0);
    check("rst_data", resp_rdata | DM_addr | DM_wdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    do_req(1, 2'd2, 0, BASE + 8, 32'hDEAD_BEEF, 0);
    do_req(0, 2'd2, 0, BASE + 8, 32'h0, 0);
    check("lw_deadbeef_model", {ref_mem[11], ref_mem[10], ref_mem[9], ref_mem[8]}, 32'hDEAD_BEEF);
    do_req(1, 2'd0, 0, BASE + 1, 32'h0000_0080, 1);
    do_req(0, 2'd0, 0, BASE + 1, 32'h0, 0);
    do_req(0, 2'd0, 1, BASE + 1, 32'h0, 0);
    do_req(0, 2'd2, 0, BASE + 0, 32'h0, 0);
    do_req(0, 2'd1, 0, BASE + 3, 32'h0, 0);
    do_req(1, 2'd2, 0, BASE + 2, 32'h1234_5678, 0);
    do_req(0, 2'd2, 0, BASE + 636, 32'h0, 0);
    do_req(0, 2'd2, 0, BASE + 637, 32'h0, 0);
    do_req(1, 2'd2, 0, BASE + 637, 32'h1, 0);
    do_req(0, 2'd2, 0, 32'h1000_FFFC, 32'h0, 0);
    do_req(0, 2'd1, 0, BASE + 638, 32'h0, 0);
    do_req(0, 2'd0, 1, BASE + 639, 32'h0, 0);
    do_req(0, 2'd0, 0, BASE + 640, 32'h0, 0);
    do_req(0, 2'd3, 0, BASE + 4, 32'h0, 0);
    do_req(1, 2'd3, 0, BASE + 4, 32'h0, 0);
    do_req(0, 2'd2, 0, BASE + 8, 32'h0, 5);

    // Reset while in RESP.
    model(0, 2'd2, 0, BASE + 8, 32'h0, f, e, r, o);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = BASE + 8;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rstresp_pre_valid", 32'(resp_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstresp_idle", {req_ready, resp_valid}, 32'd2);
    check("rstresp_rdata", resp_rdata, 32'd0);

    // Reset on the acceptance edge drops the request.
    cnt0 = ena_cycles;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = BASE + 16;
    req_wdata = 32'h1357_9BDF; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    check("rstacc_ready", 32'(req_ready), 32'd1);
    check("rstacc_ena", 32'(ena), 32'd0);
    @(posedge clk); #1;
    check("rstacc_no_resp", 32'(resp_valid), 32'd0);
    check("rstacc_ena_count", 32'(ena_cycles - cnt0), 32'd0);

    // Reset during a store's ACCESS: the falling-edge write still lands.
    model(1, 2'd2, 0, BASE + 32, 32'hCAFE_F00D, f, e, r, o);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = BASE + 32;
    req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstst_ena", 32'(ena), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstst_idle", {req_ready, resp_valid}, 32'd2);
    check("rstst_written", {mem[35], mem[34], mem[33], mem[32]}, 32'hCAFE_F00D);
    @(posedge clk); #1;

    // Randomized traffic biased around the range boundaries.
    for (int t = 0; t < 150; t++) begin
      logic [31:0] a;
      case ($urandom_range(0, 7))
        0:       a = BASE - 32'($urandom_range(1, 8));
        1:       a = BASE + 32'($urandom_range(630, 660));
        default: a = BASE + 32'($urandom_range(0, 650));
      endcase
      do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $urandom_range(0, 3));
    end

    nmis = 0;
    for (int i = 0; i < BYTES; i++) if (mem[i] !== ref_mem[i]) nmis++;
    check("mem_image", 32'(nmis), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
